// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: configurable serial pattern detector with a run sequencer.
// A loadable pattern of 1..PW bits is compared against the most recent
// qualified serial bits. Matches may overlap and are counted with saturation.
// A non-zero threshold ends the run automatically when the count reaches it.
module seq_detect_ctrl #(
  parameter int PW = 8,
  parameter int CW = 8
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  cfg_we,
  input  logic [PW-1:0]         cfg_pat,
  input  logic [$clog2(PW):0]   cfg_len,
  input  logic [CW-1:0]         cfg_thresh,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  din,
  input  logic                  din_vld,
  output logic                  busy,
  output logic                  match,
  output logic [CW-1:0]         match_cnt,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int LW = $clog2(PW) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_pat;
  logic [LW-1:0]   r_len;
  logic [CW-1:0]   r_thresh;
  // Only PW-1 stored bits are needed: the incoming bit supplies the newest one.
  logic [PW-2:0]   r_hist;
  logic [LW-1:0]   r_fill;

  logic            w_len_ok;
  logic [PW-1:0]   w_shift;
  logic [PW-1:0]   w_mask;
  logic [LW:0]     w_fill_p1;
  logic            w_hit;
  logic [CW-1:0]   w_cnt_inc;
  logic [LW-1:0]   w_fill_inc;

  assign w_len_ok   = (cfg_len != {LW{1'b0}}) && (cfg_len <= LW'(PW));
  assign w_shift    = {r_hist, din};
  assign w_fill_p1  = {1'b0, r_fill} + (LW+1)'(1);
  assign w_hit      = (w_fill_p1 >= {1'b0, r_len}) &&
                      (((w_shift ^ r_pat) & w_mask) == {PW{1'b0}});
  assign w_cnt_inc  = (match_cnt == {CW{1'b1}}) ? match_cnt : (match_cnt + CW'(1));
  assign w_fill_inc = (r_fill == LW'(PW)) ? r_fill : (r_fill + LW'(1));

  // Compare mask: ones in the low r_len positions, upper pattern bits ignored.
  always_comb begin
    w_mask = {PW{1'b0}};
    for (int i = 0; i < PW; i++) begin
      w_mask[i] = (LW'(i) < r_len);
    end
  end

  // Controller: config loading, run sequencing, shifting, matching and counting.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_state   <= ST_IDLE;
      r_pat     <= {PW{1'b0}};
      r_len     <= LW'(1);
      r_thresh  <= {CW{1'b0}};
      r_hist    <= {(PW-1){1'b0}};
      r_fill    <= {LW{1'b0}};
      busy      <= 1'b0;
      match     <= 1'b0;
      match_cnt <= {CW{1'b0}};
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      match   <= 1'b0;
      cfg_err <= 1'b0;

      // Config is only accepted outside a run and with a legal length.
      if (cfg_we) begin
        if ((r_state != ST_RUN) && w_len_ok) begin
          r_pat    <= cfg_pat;
          r_len    <= cfg_len;
          r_thresh <= cfg_thresh;
        end else begin
          cfg_err  <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_hist    <= {(PW-1){1'b0}};
            r_fill    <= {LW{1'b0}};
            match_cnt <= {CW{1'b0}};
            done      <= 1'b0;
            busy      <= 1'b1;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else if (din_vld) begin
            r_hist <= w_shift[PW-2:0];
            r_fill <= w_fill_inc;
            if (w_hit) begin
              match     <= 1'b1;
              match_cnt <= w_cnt_inc;
              if ((r_thresh != {CW{1'b0}}) && (w_cnt_inc == r_thresh)) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                r_state <= ST_DONE;
              end
            end
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial pattern-detection controller. Holds a loadable pattern (1..PW bits), sequences arm/run/stop of detection on a qualified serial bit stream, and counts overlapping matches. Finishes automatically at a match threshold. Sits between the configuration/host side and a serial data source; replaces fixed-pattern detector FSMs with one configurable, count-reporting block.

Parameters:
PW, 8, maximum pattern width in bits (2..16)
CW, 8, width of match counter and threshold

Ports:
clk  in  1  clock, all logic on rising edge
res  in  1  reset, synchronous, active-low
cfg_we  in  1  configuration write strobe
cfg_pat  in  PW  pattern; cfg_pat[len-1] = first bit received, cfg_pat[0] = last
cfg_len  in  $clog2(PW)+1  pattern length, legal 1..PW
cfg_thresh  in  CW  matches to finish; 0 = run until stop
start  in  1  begin detection run (pulse)
stop  in  1  abort run (pulse)
din  in  1  serial data bit
din_vld  in  1  din qualifier
busy  out  1  high in RUN
match  out  1  one-cycle pulse per detected pattern
match_cnt  out  CW  matches in current/last run
done  out  1  threshold reached; level
cfg_err  out  1  one-cycle pulse on rejected config write

Behaviour:
- Reset (res=0 at a clk edge): state IDLE; busy, match, done, cfg_err, match_cnt = 0; pattern = 0, len = 1, thresh = 0; history and fill cleared. Reset overrides all other inputs, including mid-run.
- States: IDLE, RUN, DONE. busy = (state==RUN), registered.
- Config: cfg_we in IDLE or DONE with cfg_len in 1..PW loads pat/len/thresh at that edge. cfg_we in RUN, or cfg_len outside 1..PW: no change, cfg_err=1 for one cycle.
- start in IDLE/DONE: clears history, fill counter, match_cnt, done; state becomes RUN at that edge. din on the start cycle is not sampled. start in RUN: ignored.
- RUN: on each din_vld=1 cycle, shift din into history (PW bits) and increment fill (saturating at PW). Cycles with din_vld=0 change nothing.
- Match condition, evaluated on the sampled bit: (fill+1 >= len) and the low len bits of {history,din} equal the low len bits of pat.
- Overlap is allowed; history is not cleared on a match.
- Match latency: match=1 in the cycle after the completing din_vld cycle. match_cnt increments on the same edge and saturates at 2^CW-1.
- Threshold: if thresh!=0 and the incremented count == thresh, then done=1 and state becomes DONE on that same edge. Further din is ignored. done stays high until the next start or reset. A cfg_we does not clear done.
- stop in RUN: state becomes IDLE next edge; match_cnt is held. stop has priority: the bit on the stop cycle is not evaluated. stop in IDLE/DONE: ignored.
- Simultaneous start+stop: start wins in IDLE/DONE; stop wins in RUN.
- Simultaneous cfg_we+start in IDLE: config loads, and the run uses the new config.
- Unused high pattern bits beyond len are don't-care.

Test Plan:
1. Overlapping detection: pat=1011, len=4, thresh=0, start, then stream 1,0,1,1,0,1,1 all valid -> match pulses one cycle after bit 4 and after bit 7; match_cnt=2; busy stays 1; done=0.
2. Threshold: thresh=2, stream 1,0,1,1,0,1,1,0,1,1 -> done=1 and busy=0 on the edge with the 2nd match. Third pattern yields no match; match_cnt stays 2. A following start clears done and match_cnt.
3. Valid gaps: pat=1011 with din_vld low for 3 cycles between each bit (din toggling during gaps) -> exactly one match pulse, one cycle after the 4th valid bit.
4. Config errors: cfg_we during RUN -> cfg_err pulse, pattern unchanged (verify old pattern still matches). cfg_len=0 and cfg_len=PW+1 in IDLE -> cfg_err each time, no load.
5. Stop/restart and reset: feed 1,0,1 then stop -> IDLE, match_cnt held. Then start and feed 1 -> no match, since history is cleared. Drive res=0 mid-run -> next cycle all outputs 0, state IDLE.
6. Saturation with CW=2: pat=1, len=1, thresh=0, feed five valid 1s -> five match pulses; match_cnt reads 1,2,3,3,3.
